// File: rtl/code_lock_ctrl_pkg.sv
// ============================================================================
//  code_lock_ctrl_pkg : shared encodings and helpers for the colour code lock
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package code_lock_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ENTRY   = 3'd1,
      ST_OPEN    = 3'd2,
      ST_PROG    = 3'd3,
      ST_LOCKOUT = 3'd4
   } state_e;

   typedef logic [1:0] sym_t;

   localparam sym_t SYM_NONE  = 2'b00;
   localparam sym_t SYM_RED   = 2'b01;
   localparam sym_t SYM_GREEN = 2'b10;
   localparam sym_t SYM_BLUE  = 2'b11;

   // Sequence R,B,G,R with the first symbol in the least significant pair.
   localparam logic [7:0] DEFAULT_CODE = {SYM_RED, SYM_GREEN, SYM_BLUE, SYM_RED};

   typedef struct packed {
      logic active;
      logic valid;
      sym_t sym;
   } sym_dec_t;

   function automatic sym_dec_t decode_sym(input logic r, input logic g, input logic b);
      sym_dec_t   d;
      logic [1:0] n;
      n        = {1'b0, r} + {1'b0, g} + {1'b0, b};
      d.active = r | g | b;
      d.valid  = (n == 2'd1);
      d.sym    = r ? SYM_RED : (g ? SYM_GREEN : (b ? SYM_BLUE : SYM_NONE));
      return d;
   endfunction

   function automatic logic [1:0] sat_inc(input logic [1:0] v);
      return (v == 2'd3) ? v : v + 2'd1;
   endfunction

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

`default_nettype wire

// File: rtl/code_lock_ctrl_timer.sv
// ============================================================================
//  lock_timer : loadable down-counter, expire flags a count of zero
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module lock_timer #(
   parameter int unsigned W = 4
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         en_i,
   output logic         expire_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/code_lock_ctrl.sv
// ============================================================================
//  code_lock_ctrl : four-symbol colour code lock with programming and lockout
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module code_lock_ctrl
   import code_lock_ctrl_pkg::*;
#(
   parameter int unsigned OPEN_CYCLES    = 8,
   parameter int unsigned LOCKOUT_CYCLES = 32,
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned MAX_FAIL       = 3
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       start_i,
   input  logic       red_i,
   input  logic       green_i,
   input  logic       blue_i,
   input  logic       prog_i,
   output logic       unlock_o,
   output logic       locked_o,
   output logic [1:0] fail_cnt_o
);

   localparam int unsigned MAX_CYC = max3(OPEN_CYCLES, LOCKOUT_CYCLES, TIMEOUT_CYCLES);
   localparam int unsigned TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   // The timer expires when it reaches zero, so each reload is one less than the dwell.
   localparam logic [TMR_W-1:0] OPEN_LD = TMR_W'(OPEN_CYCLES - 1);
   localparam logic [TMR_W-1:0] LOCK_LD = TMR_W'(LOCKOUT_CYCLES - 1);
   localparam logic [TMR_W-1:0] TOUT_LD = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0]       MAX_FAIL_C = 2'(MAX_FAIL);

   state_e     state_q, state_d;
   logic [1:0] idx_q, idx_d;
   logic       flag_q, flag_d;
   logic [1:0] fail_q, fail_d;
   logic [7:0] code_q, code_d;
   logic [5:0] shadow_q, shadow_d;
   logic       unlock_q, unlock_d;
   logic       locked_q, locked_d;

   sym_dec_t         dec;
   logic [1:0]       fail_inc;
   sym_t             exp_sym;
   logic             mism;
   logic             tmr_load;
   logic [TMR_W-1:0] tmr_val;
   logic             tmr_en;
   logic             tmr_expire;

   assign dec      = decode_sym(red_i, green_i, blue_i);
   assign fail_inc = sat_inc(fail_q);
   assign exp_sym  = code_q[{idx_q, 1'b0} +: 2];

   lock_timer #(
      .W (TMR_W)
   ) u_timer (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .en_i       (tmr_en),
      .expire_o   (tmr_expire)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= ST_IDLE;
         idx_q    <= 2'd0;
         flag_q   <= 1'b0;
         fail_q   <= 2'd0;
         code_q   <= DEFAULT_CODE;
         shadow_q <= 6'd0;
         unlock_q <= 1'b0;
         locked_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         flag_q   <= flag_d;
         fail_q   <= fail_d;
         code_q   <= code_d;
         shadow_q <= shadow_d;
         unlock_q <= unlock_d;
         locked_q <= locked_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      flag_d   = flag_q;
      fail_d   = fail_q;
      code_d   = code_q;
      shadow_d = shadow_q;
      mism     = flag_q | ~dec.valid | (dec.sym != exp_sym);
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_ENTRY;
               idx_d   = 2'd0;
               flag_d  = 1'b0;
            end
         end
         ST_ENTRY: begin
            if (start_i) begin
               // A restart is charged as a failed attempt.
               fail_d = fail_inc;
               idx_d  = 2'd0;
               flag_d = 1'b0;
               if (fail_inc == MAX_FAIL_C) begin
                  state_d = ST_LOCKOUT;
               end
            end else if (dec.active) begin
               if (idx_q == 2'd3) begin
                  if (!mism) begin
                     state_d = ST_OPEN;
                     fail_d  = 2'd0;
                  end else begin
                     fail_d  = fail_inc;
                     state_d = (fail_inc == MAX_FAIL_C) ? ST_LOCKOUT : ST_IDLE;
                  end
               end else begin
                  idx_d  = idx_q + 2'd1;
                  flag_d = mism;
               end
            end else if (tmr_expire) begin
               state_d = ST_IDLE;
            end
         end
         ST_OPEN: begin
            if (start_i && prog_i) begin
               state_d = ST_PROG;
               idx_d   = 2'd0;
            end else if (tmr_expire) begin
               state_d = ST_IDLE;
            end
         end
         ST_PROG: begin
            if (start_i || (dec.active && !dec.valid)) begin
               state_d = ST_IDLE;
            end else if (dec.active) begin
               case (idx_q)
                  2'd0:    shadow_d[1:0] = dec.sym;
                  2'd1:    shadow_d[3:2] = dec.sym;
                  2'd2:    shadow_d[5:4] = dec.sym;
                  default: begin
                     code_d  = {dec.sym, shadow_q};
                     state_d = ST_IDLE;
                  end
               endcase
               idx_d = idx_q + 2'd1;
            end else if (tmr_expire) begin
               state_d = ST_IDLE;
            end
         end
         ST_LOCKOUT: begin
            if (tmr_expire) begin
               state_d = ST_IDLE;
               fail_d  = 2'd0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Single shared timer: reloaded on any state change and on activity while keying in.
   always_comb begin
      tmr_en   = (state_q != ST_IDLE);
      tmr_load = (state_d != state_q) ||
                 (((state_q == ST_ENTRY) || (state_q == ST_PROG)) && (start_i || dec.active));
      case (state_d)
         ST_OPEN:    tmr_val = OPEN_LD;
         ST_LOCKOUT: tmr_val = LOCK_LD;
         default:    tmr_val = TOUT_LD;
      endcase
   end

   // Outputs trail the state by one edge; leaving OPEN for PROG drops Unlock at once.
   always_comb begin
      unlock_d = (state_q == ST_OPEN) && (state_d != ST_PROG);
      locked_d = (state_q == ST_LOCKOUT);
   end

   assign unlock_o   = unlock_q;
   assign locked_o   = locked_q;
   assign fail_cnt_o = fail_q;

endmodule

`default_nettype wire

// File: tb/tb_code_lock_ctrl.sv
// ============================================================================
//  tb_code_lock_ctrl : directed and randomized checks against a behavioural model
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_code_lock_ctrl;

   localparam int OPEN_CYCLES    = 8;
   localparam int LOCKOUT_CYCLES = 32;
   localparam int TIMEOUT_CYCLES = 16;
   localparam int MAX_FAIL       = 3;

   localparam int M_IDLE  = 0;
   localparam int M_ENTRY = 1;
   localparam int M_OPEN  = 2;
   localparam int M_PROG  = 3;
   localparam int M_LOCK  = 4;

   logic       clk;
   logic       rst_n;
   logic       start, red, green, blue, prog;
   logic       unlock, locked;
   logic [1:0] fail_cnt;

   int n_checks = 0;
   int n_errors = 0;
   int u_cycles = 0;
   int l_cycles = 0;

   // Behavioural model: symbols 1=R 2=G 3=B, -1 = several colours at once.
   int m_mode;
   int m_code[4];
   int m_seq[$];
   int m_fails, m_idle, m_left;
   int m_unlock, m_locked;

   code_lock_ctrl #(
      .OPEN_CYCLES    (OPEN_CYCLES),
      .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .MAX_FAIL       (MAX_FAIL)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .start_i    (start),
      .red_i      (red),
      .green_i    (green),
      .blue_i     (blue),
      .prog_i     (prog),
      .unlock_o   (unlock),
      .locked_o   (locked),
      .fail_cnt_o (fail_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode   = M_IDLE;
      m_code   = '{1, 3, 2, 1};
      m_seq.delete();
      m_fails  = 0;
      m_idle   = 0;
      m_left   = 0;
      m_unlock = 0;
      m_locked = 0;
   endtask

   task automatic model_fail(input bit restart);
      m_fails = (m_fails < 3) ? m_fails + 1 : 3;
      if (m_fails == MAX_FAIL) begin
         m_mode = M_LOCK;
         m_left = LOCKOUT_CYCLES;
      end else if (restart) begin
         m_seq.delete();
         m_idle = 0;
      end else begin
         m_mode = M_IDLE;
      end
   endtask

   task automatic model_step(input bit s, input bit p, input bit r, input bit g, input bit b);
      int  sym;
      int  n;
      bit  was_open, was_lock, to_prog, ok;
      n        = int'(r) + int'(g) + int'(b);
      sym      = (n == 0) ? 0 : (n > 1) ? -1 : r ? 1 : g ? 2 : 3;
      was_open = (m_mode == M_OPEN);
      was_lock = (m_mode == M_LOCK);
      to_prog  = 1'b0;
      case (m_mode)
         M_IDLE: if (s) begin
            m_mode = M_ENTRY;
            m_seq.delete();
            m_idle = 0;
         end
         M_ENTRY: begin
            if (s) begin
               model_fail(1'b1);
            end else if (sym != 0) begin
               m_seq.push_back(sym);
               m_idle = 0;
               if (m_seq.size() == 4) begin
                  ok = 1'b1;
                  for (int i = 0; i < 4; i++) if (m_seq[i] != m_code[i]) ok = 1'b0;
                  if (ok) begin
                     m_mode  = M_OPEN;
                     m_left  = OPEN_CYCLES;
                     m_fails = 0;
                  end else begin
                     model_fail(1'b0);
                  end
               end
            end else begin
               m_idle++;
               if (m_idle == TIMEOUT_CYCLES) m_mode = M_IDLE;
            end
         end
         M_OPEN: begin
            if (s && p) begin
               m_mode  = M_PROG;
               to_prog = 1'b1;
               m_seq.delete();
               m_idle  = 0;
            end else begin
               m_left--;
               if (m_left == 0) m_mode = M_IDLE;
            end
         end
         M_PROG: begin
            if (s || sym == -1) begin
               m_mode = M_IDLE;
            end else if (sym != 0) begin
               m_seq.push_back(sym);
               m_idle = 0;
               if (m_seq.size() == 4) begin
                  for (int i = 0; i < 4; i++) m_code[i] = m_seq[i];
                  m_mode = M_IDLE;
               end
            end else begin
               m_idle++;
               if (m_idle == TIMEOUT_CYCLES) m_mode = M_IDLE;
            end
         end
         default: begin
            m_left--;
            if (m_left == 0) begin
               m_mode  = M_IDLE;
               m_fails = 0;
            end
         end
      endcase
      m_unlock = (was_open && !to_prog) ? 1 : 0;
      m_locked = was_lock ? 1 : 0;
   endtask

   // One clock cycle: inputs applied at the falling edge, outputs checked at the next.
   task automatic cyc(input bit s, input bit p, input bit r, input bit g, input bit b);
      start = s; prog = p; red = r; green = g; blue = b;
      @(posedge clk);
      if (rst_n) model_step(s, p, r, g, b);
      @(negedge clk);
      check("unlock", int'(unlock), m_unlock);
      check("locked", int'(locked), m_locked);
      check("fail_cnt", int'(fail_cnt), m_fails);
      if (unlock) u_cycles++;
      if (locked) l_cycles++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
   endtask

   task automatic send_sym(input int sym);
      int k;
      case (sym)
         1: cyc(0, 0, 1, 0, 0);
         2: cyc(0, 0, 0, 1, 0);
         3: cyc(0, 0, 0, 0, 1);
         default: begin
            k = int'($urandom_range(0, 3));
            case (k)
               0:       cyc(0, 0, 1, 1, 0);
               1:       cyc(0, 0, 1, 0, 1);
               2:       cyc(0, 0, 0, 1, 1);
               default: cyc(0, 0, 1, 1, 1);
            endcase
         end
      endcase
   endtask

   task automatic gap(input int gmax);
      if (gmax > 0) begin
         if ($urandom_range(0, 15) == 0) idle(int'($urandom_range(14, 17)));
         else idle(int'($urandom_range(0, gmax)));
      end
   endtask

   task automatic entry(input int a, input int b, input int c, input int d, input int gmax);
      cyc(1, 0, 0, 0, 0);
      send_sym(a); gap(gmax);
      send_sym(b); gap(gmax);
      send_sym(c); gap(gmax);
      send_sym(d);
   endtask

   task automatic do_reset();
      start = 0; prog = 0; red = 0; green = 0; blue = 0;
      #2 rst_n = 1'b0;
      #1;
      check("rst_unlock", int'(unlock), 0);
      check("rst_locked", int'(locked), 0);
      check("rst_fail", int'(fail_cnt), 0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   int pick_sym;
   int syms[4];

   initial begin
      rst_n = 1'b0;
      start = 0; prog = 0; red = 0; green = 0; blue = 0;
      model_reset();
      #1;
      check("init_unlock", int'(unlock), 0);
      check("init_locked", int'(locked), 0);
      check("init_fail", int'(fail_cnt), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Default code opens for exactly OPEN_CYCLES.
      u_cycles = 0;
      entry(1, 3, 2, 1, 0);
      check("unlock_delay", int'(unlock), 0);
      idle(12);
      check("open_len", u_cycles, 8);

      // Three wrong entries lead to a lockout that ignores inputs.
      entry(1, 1, 1, 1, 0);
      check("fail_1", int'(fail_cnt), 1);
      idle(1);
      entry(1, 1, 1, 1, 0);
      check("fail_2", int'(fail_cnt), 2);
      idle(1);
      l_cycles = 0;
      entry(1, 1, 1, 1, 0);
      for (int i = 0; i < 10; i++) cyc(1, 1, i[0], i[1], i[2]);
      idle(30);
      check("lock_len", l_cycles, 32);
      check("lock_end", int'(locked), 0);
      check("lock_fail_clr", int'(fail_cnt), 0);

      // Invalid symbol counts as a failure; a correct entry then clears it.
      entry(1, -1, 2, 1, 0);
      check("invalid_fail", int'(fail_cnt), 1);
      idle(2);
      entry(1, 3, 2, 1, 0);
      check("open_clears_fail", int'(fail_cnt), 0);
      idle(12);

      // Idle timeout in ENTRY does not count a failure.
      cyc(1, 0, 0, 0, 0);
      send_sym(1);
      idle(16);
      entry(1, 3, 2, 1, 0);
      idle(1);
      check("after_timeout_open", int'(unlock), 1);
      idle(10);

      // Reprogram to G,G,B,B; the old code must then fail and the new one open.
      entry(1, 3, 2, 1, 0);
      idle(2);
      cyc(1, 1, 0, 0, 0);
      check("prog_unlock_low", int'(unlock), 0);
      send_sym(2); send_sym(2); send_sym(3); send_sym(3);
      idle(2);
      entry(1, 3, 2, 1, 0);
      check("old_code_fails", int'(fail_cnt), 1);
      idle(2);
      entry(2, 2, 3, 3, 0);
      idle(1);
      check("new_code_opens", int'(unlock), 1);
      idle(10);

      // Reset mid-OPEN restores the default code; reset mid-LOCKOUT clears everything.
      do_reset();
      entry(1, 3, 2, 1, 0);
      idle(3);
      check("default_restored", int'(unlock), 1);
      do_reset();
      for (int i = 0; i < 3; i++) begin
         entry(1, 1, 1, 1, 0);
         idle(1);
      end
      idle(4);
      check("in_lockout", int'(locked), 1);
      do_reset();
      idle(2);

      // Randomized traffic against the model.
      for (int it = 0; it < 300; it++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: begin
               for (int i = 0; i < 4; i++) begin
                  pick_sym = int'($urandom_range(0, 9));
                  if ($urandom_range(0, 1) == 0)  syms[i] = m_code[i];
                  else if (pick_sym == 0)         syms[i] = -1;
                  else                            syms[i] = int'($urandom_range(1, 3));
               end
               entry(syms[0], syms[1], syms[2], syms[3], 2);
            end
            4: idle(int'($urandom_range(0, 40)));
            5: begin
               cyc(1, 1, 0, 0, 0);
               for (int i = 0; i < 4; i++) begin
                  send_sym(($urandom_range(0, 11) == 0) ? -1 : int'($urandom_range(1, 3)));
                  gap(2);
               end
            end
            6: for (int i = 0; i < 6; i++)
                  cyc($urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 1) == 1);
            7: if ($urandom_range(0, 2) == 0) do_reset(); else idle(3);
            8: begin
               cyc(1, 0, 0, 0, 0);
               idle(int'($urandom_range(0, 17)));
            end
            default: cyc(0, 1, $urandom_range(0, 1) == 1, 0, $urandom_range(0, 1) == 1);
         endcase
      end
      idle(40);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
